// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit display scanner: prescaled digit rotation, frame-aligned
// value updates through a shadow register, and optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_in,
  input  logic        load,
  input  logic        blank_lz,
  output logic [31:0] number,
  output logic [2:0]  anodeCounter,
  output logic        digit_en,
  output logic        tick,
  output logic        frame_done,
  output logic        pending
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_reg;
  logic [2:0]    anode_reg;
  logic [31:0]   number_reg;
  logic [31:0]   shadow_reg;
  logic          pending_reg;
  logic          tick_reg;
  logic          frame_done_reg;

  logic advance;
  logic wrap;

  assign advance = (presc_reg == PRESC_LAST);
  assign wrap    = advance && (anode_reg == 3'd7);

  // Free-running prescaler and digit counter; nothing ever stalls the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg      <= '0;
      anode_reg      <= 3'd0;
      tick_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      presc_reg      <= advance ? '0 : presc_reg + PW'(1);
      tick_reg       <= advance;
      frame_done_reg <= wrap;
      if (advance) begin
        anode_reg <= anode_reg + 3'd1;
      end
    end
  end

  // Loads land in the shadow register; number only changes on the wrap edge so
  // a frame never shows a mix of old and new digits. A load on the wrap edge
  // itself goes straight to number.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_reg  <= 32'd0;
      shadow_reg  <= 32'd0;
      pending_reg <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        number_reg <= value_in;
        shadow_reg <= value_in;
      end else if (pending_reg) begin
        number_reg <= shadow_reg;
      end
      pending_reg <= 1'b0;
    end else if (load) begin
      shadow_reg  <= value_in;
      pending_reg <= 1'b1;
    end
  end

  // upper_zero[i] is set when nibbles i..7 of number are all zero.
  logic [7:0] nib_zero;
  logic [7:0] upper_zero;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_nib
      assign nib_zero[gi] = (number_reg[4*gi +: 4] == 4'h0);
    end
    for (gi = 0; gi < 7; gi++) begin : g_upper
      assign upper_zero[gi] = nib_zero[gi] & upper_zero[gi+1];
    end
  endgenerate
  assign upper_zero[7] = nib_zero[7];

  // Digit 0 is never blanked so a zero value still shows a single "0".
  assign digit_en = !(blank_lz && (anode_reg != 3'd0) && upper_zero[anode_reg]);

  assign number       = number_reg;
  assign anodeCounter = anode_reg;
  assign tick         = tick_reg;
  assign frame_done   = frame_done_reg;
  assign pending      = pending_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed testbench for display_scan_ctrl with REFRESH_DIV=4 (frame = 32 edges).
module tb_display_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] value_in;
  logic        load;
  logic        blank_lz;
  logic [31:0] number;
  logic [2:0]  anodeCounter;
  logic        digit_en;
  logic        tick;
  logic        frame_done;
  logic        pending;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;   // rising edges since the last reset release

  display_scan_ctrl #(.REFRESH_DIV(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .value_in     (value_in),
    .load         (load),
    .blank_lz     (blank_lz),
    .number       (number),
    .anodeCounter (anodeCounter),
    .digit_en     (digit_en),
    .tick         (tick),
    .frame_done   (frame_done),
    .pending      (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ecnt++;
    end
  endtask

  // Advance until the given edge count has just happened.
  task automatic adv_to(input int e);
    if (e > ecnt) adv(e - ecnt);
  endtask

  // Present value_in with load=1 across exactly the next edge.
  task automatic do_load(input logic [31:0] v);
    value_in = v;
    load     = 1'b1;
    adv(1);
    load     = 1'b0;
    $display("load 0x%08h captured at edge %0d", v, ecnt);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; value_in = 32'd0; blank_lz = 1'b0;
    #2;
    checks++;
    if (number !== 32'd0 || anodeCounter !== 3'd0 || pending !== 1'b0 ||
        tick !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: num=%h an=%0d pend=%b tick=%b fd=%b required all 0",
               number, anodeCounter, pending, tick, frame_done);
    end
    checks++;
    if (digit_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_digit_en: got %b required 1", digit_en);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ecnt  = 0;
    $display("reset released");
  endtask

  task automatic test_scan;
    for (int e = 1; e <= 32; e++) begin
      adv(1);
      checks++;
      if (tick !== (e % 4 == 0) || anodeCounter !== 3'((e / 4) % 8) ||
          frame_done !== (e == 32)) begin
        errors++;
        $display("FAIL scan_e%0d: tick=%b an=%0d fd=%b required tick=%b an=%0d fd=%b",
                 e, tick, anodeCounter, frame_done, (e % 4 == 0), (e / 4) % 8, (e == 32));
      end
    end
    $display("scan frame complete at edge %0d", ecnt);
  endtask

  task automatic test_load;
    adv_to(44);                       // anodeCounter=3 during edges 44..47
    do_load(32'h12345678);
    checks++;
    if (pending !== 1'b1 || number !== 32'd0) begin
      errors++;
      $display("FAIL load_pending: pend=%b num=%h required 1/00000000", pending, number);
    end
    adv_to(63);
    checks++;
    if (pending !== 1'b1 || number !== 32'd0) begin
      errors++;
      $display("FAIL load_hold: pend=%b num=%h required 1/00000000", pending, number);
    end
    adv(1);
    checks++;
    if (pending !== 1'b0 || number !== 32'h12345678 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL load_wrap: pend=%b num=%h fd=%b required 0/12345678/1",
               pending, number, frame_done);
    end
  endtask

  task automatic test_back_to_back;
    adv_to(69);
    do_load(32'hAAAA0000);
    adv_to(79);
    do_load(32'h0000BBBB);
    adv_to(95);
    checks++;
    if (number !== 32'h12345678 || pending !== 1'b1) begin
      errors++;
      $display("FAIL b2b_hold: num=%h pend=%b required 12345678/1", number, pending);
    end
    adv(1);
    checks++;
    if (number !== 32'h0000BBBB || pending !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wrap: num=%h pend=%b required 0000bbbb/0", number, pending);
    end
  endtask

  task automatic test_wrap_load;
    adv_to(127);
    do_load(32'hCAFEF00D);            // edge 128 is a wrap edge
    checks++;
    if (number !== 32'hCAFEF00D || pending !== 1'b0 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap_load: num=%h pend=%b fd=%b required cafef00d/0/1",
               number, pending, frame_done);
    end
  endtask

  task automatic test_blanking;
    blank_lz = 1'b1;
    adv_to(159);
    do_load(32'h00000450);            // edge 160 wrap
    checks++;
    if (number !== 32'h00000450) begin
      errors++;
      $display("FAIL blank_number: got %h required 00000450", number);
    end
    for (int k = 0; k < 8; k++) begin
      adv_to(160 + 4 * k);
      checks++;
      if (digit_en !== (k < 3)) begin
        errors++;
        $display("FAIL blank_450_an%0d: got %b required %b", k, digit_en, (k < 3));
      end
      blank_lz = 1'b0;
      #1;
      checks++;
      if (digit_en !== 1'b1) begin
        errors++;
        $display("FAIL noblank_450_an%0d: got %b required 1", k, digit_en);
      end
      blank_lz = 1'b1;
    end
    adv_to(191);
    do_load(32'h00000000);            // edge 192 wrap
    for (int k = 0; k < 8; k++) begin
      adv_to(192 + 4 * k);
      checks++;
      if (digit_en !== (k == 0)) begin
        errors++;
        $display("FAIL blank_zero_an%0d: got %b required %b", k, digit_en, (k == 0));
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_reset_mid;
    adv_to(229);
    do_load(32'h5A5A5A5A);
    adv_to(245);                      // anodeCounter=5, pending=1
    checks++;
    if (pending !== 1'b1 || anodeCounter !== 3'd5) begin
      errors++;
      $display("FAIL rstmid_pre: pend=%b an=%0d required 1/5", pending, anodeCounter);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (number !== 32'd0 || anodeCounter !== 3'd0 || pending !== 1'b0 ||
        tick !== 1'b0 || frame_done !== 1'b0 || digit_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: num=%h an=%0d pend=%b tick=%b fd=%b en=%b required 0/0/0/0/0/1",
               number, anodeCounter, pending, tick, frame_done, digit_en);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ecnt  = 0;
    adv_to(3);
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_e3_tick: got %b required 0", tick);
    end
    adv(1);
    checks++;
    if (tick !== 1'b1 || anodeCounter !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_e4: tick=%b an=%0d required 1/1", tick, anodeCounter);
    end
    adv_to(32);
    checks++;
    if (frame_done !== 1'b1 || number !== 32'd0 || pending !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_wrap: fd=%b num=%h pend=%b required 1/00000000/0",
               frame_done, number, pending);
    end
    $display("post-reset frame complete");
  endtask

  initial begin
    test_reset;
    test_scan;
    test_load;
    test_back_to_back;
    test_wrap_load;
    test_blanking;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
